pe_sys_v2: RTL and testbench
============================

# pe_sys_v2

Second-generation processing element for the systolic matrix-multiply array. It supports two runtime-selectable dataflows:
- Output-stationary (OS): accumulates locally and shifts results out through the psum chain.
- Weight-stationary (WS): holds a preloaded weight and passes partial sums from neighbour to neighbour.

It adds per-operand valid qualification, tile clear, psum-chain drain, optional saturation and a sticky overflow flag. One instance sits at every grid point; A travels east, B and psum travel south.

## Interface
Parameters:
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 32, signed accumulator / psum width; must be ≥ 2*DATA_WIDTH
- SATURATE, 1, 1 = clamp accumulation to signed ACC_WIDTH range, 0 = two's-complement wrap

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  1  0 = OS, 1 = WS; quasi-static, changed only while valid_in=0, load_w=0, drain_in=0
- valid_in  in  1  a_in/b_in (OS) or a_in/psum_in (WS) carry a real operand
- a_in  in  DATA_WIDTH  signed activation from west
- b_in  in  DATA_WIDTH  signed operand from north (OS) / weight-load data (WS)
- psum_in  in  ACC_WIDTH  signed partial sum from north
- clear_in  in  1  OS: this valid operand starts a new tile
- drain_in  in  1  OS: shift accumulator chain by one PE
- load_w  in  1  WS: capture b_in into weight register
- valid_out, clear_out  out  1  valid_in, clear_in delayed 1 cycle (east/south neighbours)
- a_out  out  DATA_WIDTH  a_in delayed 1 cycle
- b_out  out  DATA_WIDTH  b_in delayed 1 cycle
- psum_out  out  ACC_WIDTH  OS: accumulator; WS: registered partial sum
- psum_valid_out  out  1  psum_out carries a meaningful value
- ovf  out  1  sticky overflow flag

## Operation
- Forwarding: a_out, b_out, valid_out and clear_out are registered copies of their inputs every cycle, regardless of mode, valid or drain.
- Arithmetic:
  - prod = a_in * (OS ? b_in : w), full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
  - Each sum is formed at ACC_WIDTH+1 bits.
  - Overflow occurs when bit ACC_WIDTH differs from bit ACC_WIDTH-1.
  - On overflow, SATURATE=1 gives +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1); SATURATE=0 takes the low ACC_WIDTH bits.
- OS mode, priority drain_in > valid_in:
  - drain_in=1: acc ← psum_in; psum_valid_out ← 1; any valid operand in that cycle is discarded.
  - else valid_in=1 and clear_in=1: acc ← prod; ovf ← 0.
  - else valid_in=1: acc ← acc + prod (sat/wrap); ovf ← ovf | overflow.
  - else: acc holds.
  - psum_valid_out ← drain_in.
  - load_w is ignored.
- WS mode, priority load_w > valid_in:
  - load_w=1: w ← b_in; ovf ← 0; psum_valid_out ← 0.
  - else valid_in=1: psum ← psum_in + prod (sat/wrap); ovf ← ovf | overflow; psum_valid_out ← 1.
  - else: psum holds; psum_valid_out ← 0.
  - clear_in and drain_in are ignored (still forwarded).
- A mode change leaves acc/w untouched; software clears or reloads before use.

## Timing
- All outputs are registered; latency input → output is 1 cycle. There are no combinational input-to-output paths.
- Reset (async assert, sync-safe deassert): every output, acc, w and ovf are 0.
- Reset mid-tile discards the accumulator and weight; the first cycle after deassert behaves as after power-up.
- Back-to-back valid_in every cycle is sustained; there is no bubble requirement.
- Drain of an N-deep column takes N consecutive drain_in cycles; the bottom PE presents results in row order N-1 … 0.
- Simultaneous clear_in and drain_in in OS: drain wins, clear has no effect on acc or ovf.
- ovf reflects overflows up to and including the previous edge.

## Test plan
- OS accumulate: (3,4,clear), (-2,5), (7,7) on consecutive cycles → psum_out 12, 2, 51 on the following cycles; ovf=0; a_out/b_out echo the inputs one cycle later.
- OS saturation:
  - Drain psum_in=0x7FFFFFF0, then valid (16,1) → psum_out=0x7FFFFFFF, ovf=1.
  - Same with SATURATE=0 → 0x80000000, ovf=1.
  - Next clear with (1,1) → 1, ovf=0.
- WS: load_w with b_in=-3, then valid a_in=5, psum_in=100 → psum_out=85 and psum_valid_out=1 next cycle; an idle cycle after → psum_valid_out=0, psum_out holds 85.
- Priority: OS acc=40, drain_in=1 with valid (2,2) and psum_in=9 → acc=9, psum_valid_out=1, product discarded. WS load_w=1 with valid_in=1 → w updated, psum unchanged.
- Reset mid-operation: acc=51, ovf=1, then rst_n low for 1 cycle during valid → all outputs 0 immediately (async); after release, (2,3) without clear → psum_out=6.

Source files
------------

// File: rtl/pe_sys_v2.sv
// Systolic PE with runtime OS/WS dataflow, optional saturation and a sticky overflow flag.
// All outputs are registered with 1-cycle latency. There is no backpressure; it accepts one operand per cycle.
module pe_sys_v2 #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    input  logic signed [ACC_WIDTH-1:0]  psum_in,
    input  logic                         clear_in,
    input  logic                         drain_in,
    input  logic                         load_w,
    output logic                         valid_out,
    output logic                         clear_out,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic signed [DATA_WIDTH-1:0] b_out,
    output logic signed [ACC_WIDTH-1:0]  psum_out,
    output logic                         psum_valid_out,
    output logic                         ovf
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] w;
    logic signed [DATA_WIDTH-1:0] w_nxt;
    logic signed [DATA_WIDTH-1:0] mul_b;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  addend;
    logic signed [ACC_WIDTH:0]    sum;
    logic                         sum_ovf;
    logic signed [ACC_WIDTH-1:0]  sum_res;
    logic signed [ACC_WIDTH-1:0]  acc_nxt;
    logic                         ovf_nxt;
    logic                         pvld_nxt;

    // One extra guard bit: overflow shows as disagreement between the top two bits.
    always_comb begin
        mul_b    = mode ? w : b_in;
        prod     = PW'(a_in) * PW'(mul_b);
        prod_ext = ACC_WIDTH'(prod);
        addend   = mode ? psum_in : psum_out;
        sum      = {addend[ACC_WIDTH-1], addend} + {prod_ext[ACC_WIDTH-1], prod_ext};
        sum_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        if (sum_ovf && SATURATE)
            sum_res = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            sum_res = sum[ACC_WIDTH-1:0];
    end

    // psum_out doubles as the OS accumulator and the WS partial-sum register.
    always_comb begin
        acc_nxt  = psum_out;
        w_nxt    = w;
        ovf_nxt  = ovf;
        pvld_nxt = 1'b0;
        if (!mode) begin
            pvld_nxt = drain_in;
            if (drain_in) begin
                acc_nxt = psum_in;
            end else if (valid_in && clear_in) begin
                acc_nxt = prod_ext;
                ovf_nxt = 1'b0;
            end else if (valid_in) begin
                acc_nxt = sum_res;
                ovf_nxt = ovf | sum_ovf;
            end
        end else begin
            if (load_w) begin
                w_nxt   = b_in;
                ovf_nxt = 1'b0;
            end else if (valid_in) begin
                acc_nxt  = sum_res;
                ovf_nxt  = ovf | sum_ovf;
                pvld_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out      <= 1'b0;
            clear_out      <= 1'b0;
            a_out          <= '0;
            b_out          <= '0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            ovf            <= 1'b0;
            w              <= '0;
        end else begin
            valid_out      <= valid_in;
            clear_out      <= clear_in;
            a_out          <= a_in;
            b_out          <= b_in;
            psum_out       <= acc_nxt;
            psum_valid_out <= pvld_nxt;
            ovf            <= ovf_nxt;
            w              <= w_nxt;
        end
    end

endmodule

// File: tb/tb_pe_sys_v2.sv
// Bench for pe_sys_v2: saturating and wrapping instances share stimulus and are scored against a wide-integer model.
module tb_pe_sys_v2;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk;
    logic rst_n;
    logic mode;
    logic valid_in;
    logic signed [15:0] a_in;
    logic signed [15:0] b_in;
    logic signed [31:0] psum_in;
    logic clear_in;
    logic drain_in;
    logic load_w;

    logic        valid_out0, clear_out0, pvld0, ovf0;
    logic [15:0] a_out0, b_out0;
    logic [31:0] psum_out0;
    logic        valid_out1, clear_out1, pvld1, ovf1;
    logic [15:0] a_out1, b_out1;
    logic [31:0] psum_out1;

    pe_sys_v2 #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .psum_in(psum_in),
        .clear_in(clear_in), .drain_in(drain_in), .load_w(load_w),
        .valid_out(valid_out0), .clear_out(clear_out0),
        .a_out(a_out0), .b_out(b_out0), .psum_out(psum_out0),
        .psum_valid_out(pvld0), .ovf(ovf0)
    );

    pe_sys_v2 #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .mode(mode), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .psum_in(psum_in),
        .clear_in(clear_in), .drain_in(drain_in), .load_w(load_w),
        .valid_out(valid_out1), .clear_out(clear_out1),
        .a_out(a_out1), .b_out(b_out1), .psum_out(psum_out1),
        .psum_valid_out(pvld1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ps0;
        logic [31:0] ps1;
        logic        pv;
        logic        ov0;
        logic        ov1;
        logic [15:0] a;
        logic [15:0] b;
        logic        v;
        logic        c;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    longint m_acc[2];
    logic   m_ovf[2];
    logic signed [15:0] m_w;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint fit(input longint s, input bit sat, output logic o);
        logic signed [31:0] lo;
        o = (s > MAXV) || (s < MINV);
        if (!o) return s;
        if (sat) return (s > 0) ? MAXV : MINV;
        lo = s[31:0];
        return longint'(lo);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
        m_w = '0;
    endtask

    // Advances the model by one edge using the inputs currently driven, and queues the expectation.
    task automatic model_push();
        longint prod;
        logic   o;
        exp_t   e;
        prod = longint'(a_in) * longint'(mode ? m_w : b_in);
        for (int k = 0; k < 2; k++) begin
            if (!mode) begin
                if (drain_in) begin
                    m_acc[k] = longint'(psum_in);
                end else if (valid_in && clear_in) begin
                    m_acc[k] = prod;
                    m_ovf[k] = 1'b0;
                end else if (valid_in) begin
                    m_acc[k] = fit(m_acc[k] + prod, k == 0, o);
                    m_ovf[k] = m_ovf[k] | o;
                end
            end else begin
                if (load_w) begin
                    m_ovf[k] = 1'b0;
                end else if (valid_in) begin
                    m_acc[k] = fit(longint'(psum_in) + prod, k == 0, o);
                    m_ovf[k] = m_ovf[k] | o;
                end
            end
        end
        e.pv = !mode ? drain_in : (valid_in && !load_w);
        if (mode && load_w) m_w = b_in;
        e.ps0 = m_acc[0][31:0];
        e.ps1 = m_acc[1][31:0];
        e.ov0 = m_ovf[0];
        e.ov1 = m_ovf[1];
        e.a   = a_in;
        e.b   = b_in;
        e.v   = valid_in;
        e.c   = clear_in;
        sb.push_back(e);
    endtask

    task automatic step(input logic m, input logic v, input int a, input int b,
                        input logic [31:0] p, input logic clr, input logic drn, input logic ldw);
        exp_t e;
        mode     = m;
        valid_in = v;
        a_in     = a[15:0];
        b_in     = b[15:0];
        psum_in  = p;
        clear_in = clr;
        drain_in = drn;
        load_w   = ldw;
        model_push();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("psum_sat", psum_out0, e.ps0);
            chk("psum_wrap", psum_out1, e.ps1);
            chk("pvld_sat", {31'd0, pvld0}, {31'd0, e.pv});
            chk("pvld_wrap", {31'd0, pvld1}, {31'd0, e.pv});
            chk("ovf_sat", {31'd0, ovf0}, {31'd0, e.ov0});
            chk("ovf_wrap", {31'd0, ovf1}, {31'd0, e.ov1});
            chk("a_out", {16'd0, a_out0}, {16'd0, e.a});
            chk("b_out", {16'd0, b_out1}, {16'd0, e.b});
            chk("valid_out", {31'd0, valid_out0}, {31'd0, e.v});
            chk("clear_out", {31'd0, clear_out1}, {31'd0, e.c});
        end
    endtask

    task automatic idle(input logic m);
        step(m, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_psum"}, psum_out0 | psum_out1, 32'd0);
        chk({tag, "_flags"}, {26'd0, valid_out0, clear_out0, pvld0, ovf0, pvld1, ovf1}, 32'd0);
        chk({tag, "_ab"}, {a_out0, b_out0}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mode = 1'b0; valid_in = 1'b0; a_in = '0; b_in = '0; psum_in = '0;
        clear_in = 1'b0; drain_in = 1'b0; load_w = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // OS accumulate
        step(0, 1, 3, 4, 32'd0, 1, 0, 0);
        chk("os_12", psum_out0, 32'd12);
        step(0, 1, -2, 5, 32'd0, 0, 0, 0);
        chk("os_2", psum_out0, 32'd2);
        step(0, 1, 7, 7, 32'd0, 0, 0, 0);
        chk("os_51", psum_out0, 32'd51);
        chk("os_a_echo", {16'd0, a_out0}, 32'd7);
        idle(0);

        // OS priority: drain beats valid and clear
        step(0, 1, 5, 8, 32'd0, 1, 0, 0);
        chk("os_40", psum_out0, 32'd40);
        step(0, 1, 2, 2, 32'd9, 1, 1, 0);
        chk("drain_9", psum_out0, 32'd9);
        chk("drain_pvld", {31'd0, pvld0}, 32'd1);
        step(0, 1, 1, 1, 32'd0, 0, 0, 1);   // load_w ignored in OS
        chk("os_ldw_ign", psum_out0, 32'd10);

        // OS saturation / wrap
        step(0, 0, 0, 0, 32'h7FFF_FFF0, 0, 1, 0);
        step(0, 1, 16, 1, 32'd0, 0, 0, 0);
        chk("sat_pos", psum_out0, 32'h7FFF_FFFF);
        chk("wrap_pos", psum_out1, 32'h8000_0000);
        chk("sat_ovf", {30'd0, ovf0, ovf1}, 32'd3);
        idle(0);
        step(0, 1, 1, 1, 32'd0, 1, 0, 0);
        chk("clear_1", psum_out0, 32'd1);
        chk("clear_ovf", {30'd0, ovf0, ovf1}, 32'd0);
        step(0, 0, 0, 0, 32'h8000_0005, 0, 1, 0);
        step(0, 1, -16, 1, 32'd0, 0, 0, 0);
        chk("sat_neg", psum_out0, 32'h8000_0000);
        chk("wrap_neg", psum_out1, 32'h7FFF_FFF5);
        step(0, 1, 1, 1, 32'd0, 1, 1, 0);   // clear with drain: ovf stays
        chk("drain_clr_ovf", {31'd0, ovf0}, 32'd1);

        // WS
        idle(1);
        step(1, 0, 0, -3, 32'd0, 0, 0, 1);
        step(1, 1, 5, 0, 32'd100, 0, 0, 0);
        chk("ws_85", psum_out0, 32'd85);
        chk("ws_pvld", {31'd0, pvld0}, 32'd1);
        idle(1);
        chk("ws_hold", psum_out0, 32'd85);
        chk("ws_idle_pvld", {31'd0, pvld0}, 32'd0);
        step(1, 1, 7, 2, 32'd1000, 0, 0, 1);
        chk("ws_ldw_prio", psum_out0, 32'd85);
        step(1, 1, 3, 0, 32'd0, 1, 1, 0);
        chk("ws_w2", psum_out0, 32'd6);
        step(1, 0, 0, 32767, 32'd0, 0, 0, 1);
        step(1, 1, 32767, 0, 32'h7FFF_FFFF, 0, 0, 0);
        chk("ws_sat", psum_out0, 32'h7FFF_FFFF);
        chk("ws_ovf", {31'd0, ovf0}, 32'd1);
        idle(1);

        // Random back-to-back traffic, mode switched only on idle cycles
        for (int seg = 0; seg < 6; seg++) begin
            logic m;
            m = seg[0];
            idle(m);
            for (int i = 0; i < 60; i++) begin
                step(m, $urandom_range(0, 3) != 0, int'($urandom), int'($urandom), $urandom,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            end
            idle(m);
        end

        // Reset mid-operation
        idle(0);
        step(0, 0, 0, 0, 32'h7FFF_FFFF, 0, 1, 0);
        step(0, 1, 1, 1, 32'd0, 0, 0, 0);
        step(0, 0, 0, 0, 32'd51, 0, 1, 0);
        chk("pre_rst_acc", psum_out0, 32'd51);
        chk("pre_rst_ovf", {31'd0, ovf0}, 32'd1);
        mode = 1'b0; valid_in = 1'b1; a_in = 16'sd9; b_in = 16'sd9; clear_in = 1'b0; drain_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 1, 2, 3, 32'd0, 0, 0, 0);
        chk("post_rst_6", psum_out0, 32'd6);
        chk("post_rst_ovf", {31'd0, ovf0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
